// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: sequences PC and the four pipeline registers
// (IF/ID, ID/EX, EX/MEM, MEM/WB) for load-use stalls, taken-branch flushes
// and lock/halt, with a small halt/resume FSM and wrap-around performance counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             in_CLK,
  input  logic             in_RST_N,
  input  logic [4:0]       in_ID_rs,
  input  logic [4:0]       in_ID_rt,
  input  logic             in_ID_rs_used,
  input  logic             in_ID_rt_used,
  input  logic             in_EX_memread,
  input  logic [4:0]       in_EX_rw,
  input  logic             in_EX_branch,
  input  logic             in_halt,
  input  logic             in_go,
  output logic             out_PC_EN,
  output logic             out_IFID_EN,
  output logic             out_IDEX_EN,
  output logic             out_EXMEM_EN,
  output logic             out_MEMWB_EN,
  output logic             out_IFID_CLR,
  output logic             out_IDEX_CLR,
  output logic             out_EXMEM_CLR,
  output logic             out_MEMWB_CLR,
  output logic [1:0]       out_state,
  output logic [CNT_W-1:0] out_cycles,
  output logic [CNT_W-1:0] out_stalls,
  output logic [CNT_W-1:0] out_flushes
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] stalls_q, stalls_d;
  logic [CNT_W-1:0] flushes_q, flushes_d;

  logic loadUse;
  logic freeze;
  logic selFlush;
  logic selStall;
  logic countCycle;

  // Hazard detection and rule selection; register 0 never creates a dependency
  always_comb begin
    loadUse = in_EX_memread && (in_EX_rw != 5'd0) &&
              ((in_ID_rs_used && (in_ID_rs == in_EX_rw)) ||
               (in_ID_rt_used && (in_ID_rt == in_EX_rw)));
    freeze     = (state_q == ST_HALT) || ((state_q == ST_RUN) && in_halt);
    selFlush   = in_RST_N && !freeze && in_EX_branch;
    selStall   = in_RST_N && !freeze && !in_EX_branch && loadUse;
    countCycle = in_RST_N && !freeze;
  end

  // Stage enable/clear decode: reset, then freeze, then flush, then stall, then normal flow
  always_comb begin
    out_PC_EN     = 1'b1;
    out_IFID_EN   = 1'b1;
    out_IDEX_EN   = 1'b1;
    out_EXMEM_EN  = 1'b1;
    out_MEMWB_EN  = 1'b1;
    out_IFID_CLR  = 1'b0;
    out_IDEX_CLR  = 1'b0;
    out_EXMEM_CLR = 1'b0;
    out_MEMWB_CLR = 1'b0;
    if (!in_RST_N) begin
      out_PC_EN     = 1'b0;
      out_IFID_EN   = 1'b0;
      out_IDEX_EN   = 1'b0;
      out_EXMEM_EN  = 1'b0;
      out_MEMWB_EN  = 1'b0;
      out_IFID_CLR  = 1'b1;
      out_IDEX_CLR  = 1'b1;
      out_EXMEM_CLR = 1'b1;
      out_MEMWB_CLR = 1'b1;
    end else if (freeze) begin
      out_PC_EN    = 1'b0;
      out_IFID_EN  = 1'b0;
      out_IDEX_EN  = 1'b0;
      out_EXMEM_EN = 1'b0;
      out_MEMWB_EN = 1'b0;
    end else if (in_EX_branch) begin
      out_IFID_CLR = 1'b1;
      out_IDEX_CLR = 1'b1;
    end else if (loadUse) begin
      out_PC_EN    = 1'b0;
      out_IFID_EN  = 1'b0;
      out_IDEX_CLR = 1'b1;
    end
  end

  // Counter next values; each wraps naturally at its width
  always_comb begin
    cycles_d  = countCycle ? cycles_q  + CNT_ONE : cycles_q;
    stalls_d  = selStall   ? stalls_q  + CNT_ONE : stalls_q;
    flushes_d = selFlush   ? flushes_q + CNT_ONE : flushes_q;
  end

  // Halt/resume FSM; RESUME lasts exactly one cycle so the lock instruction drains once
  always_ff @(posedge in_CLK) begin
    if (!in_RST_N) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:    state_q <= in_halt ? ST_HALT : ST_RUN;
        ST_HALT:   state_q <= in_go ? ST_RESUME : ST_HALT;
        ST_RESUME: state_q <= ST_RUN;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

  // Performance counter registers; reset wins over any same-cycle increment
  always_ff @(posedge in_CLK) begin
    if (!in_RST_N) begin
      cycles_q  <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      cycles_q  <= cycles_d;
      stalls_q  <= stalls_d;
      flushes_q <= flushes_d;
    end
  end

  assign out_state   = state_q;
  assign out_cycles  = cycles_q;
  assign out_stalls  = stalls_q;
  assign out_flushes = flushes_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: a behavioural reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W    = 4;
  localparam int CNT_MASK = (1 << CNT_W) - 1;

  // Control word layout: {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN,
  //                       IFID_CLR, IDEX_CLR, EXMEM_CLR, MEMWB_CLR}
  localparam logic [8:0] CTL_RESET  = 9'b00000_1111;
  localparam logic [8:0] CTL_FREEZE = 9'b00000_0000;
  localparam logic [8:0] CTL_FLUSH  = 9'b11111_1100;
  localparam logic [8:0] CTL_STALL  = 9'b00111_0100;
  localparam logic [8:0] CTL_NORMAL = 9'b11111_0000;

  logic             clock = 1'b0;
  logic             rstN;
  logic [4:0]       idRs, idRt, exRw;
  logic             rsUsed, rtUsed, exMemRead, exBranch, halt, go;
  logic             pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic             ifidClr, idexClr, exmemClr, memwbClr;
  logic [1:0]       dutState;
  logic [CNT_W-1:0] dutCycles, dutStalls, dutFlushes;
  logic [8:0]       dutCtl;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: values the DUT must show after the next posedge
  int  mState    = 0;
  int  mCycles   = 0;
  int  mStalls   = 0;
  int  mFlushes  = 0;
  bit  mValid    = 1'b0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .in_CLK        (clock),
    .in_RST_N      (rstN),
    .in_ID_rs      (idRs),
    .in_ID_rt      (idRt),
    .in_ID_rs_used (rsUsed),
    .in_ID_rt_used (rtUsed),
    .in_EX_memread (exMemRead),
    .in_EX_rw      (exRw),
    .in_EX_branch  (exBranch),
    .in_halt       (halt),
    .in_go         (go),
    .out_PC_EN     (pcEn),
    .out_IFID_EN   (ifidEn),
    .out_IDEX_EN   (idexEn),
    .out_EXMEM_EN  (exmemEn),
    .out_MEMWB_EN  (memwbEn),
    .out_IFID_CLR  (ifidClr),
    .out_IDEX_CLR  (idexClr),
    .out_EXMEM_CLR (exmemClr),
    .out_MEMWB_CLR (memwbClr),
    .out_state     (dutState),
    .out_cycles    (dutCycles),
    .out_stalls    (dutStalls),
    .out_flushes   (dutFlushes)
  );

  always #5 clock = ~clock;

  assign dutCtl = {pcEn, ifidEn, idexEn, exmemEn, memwbEn,
                   ifidClr, idexClr, exmemClr, memwbClr};

  // One comparison of an actual value against a required value
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the active edge
  task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic rsU, input logic rtU, input logic memRd,
                               input logic [4:0] rw, input logic br, input logic hlt,
                               input logic goIn);
    @(posedge clock);
    #1;
    rstN = rst; idRs = rs; idRt = rt; rsUsed = rsU; rtUsed = rtU;
    exMemRead = memRd; exRw = rw; exBranch = br; halt = hlt; go = goIn;
  endtask

  task automatic quiet();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  // Reference model: derive expected controls from the rules, check, then advance
  always @(negedge clock) begin
    logic [8:0] expCtl;
    bit         depends;
    bit         frozen;
    int         rule;
    depends = 1'b0;
    if (exMemRead && exRw != 0) begin
      if (rsUsed && idRs == exRw) depends = 1'b1;
      if (rtUsed && idRt == exRw) depends = 1'b1;
    end
    frozen = (mState == 1) || (mState == 0 && halt);
    if (!rstN)          rule = 1;
    else if (frozen)    rule = 2;
    else if (exBranch)  rule = 3;
    else if (depends)   rule = 4;
    else                rule = 5;
    case (rule)
      1:       expCtl = CTL_RESET;
      2:       expCtl = CTL_FREEZE;
      3:       expCtl = CTL_FLUSH;
      4:       expCtl = CTL_STALL;
      default: expCtl = CTL_NORMAL;
    endcase
    checkOutput("ctl", 32'(dutCtl), 32'(expCtl));
    if (mValid) begin
      checkOutput("state",   32'(dutState),   mState);
      checkOutput("cycles",  32'(dutCycles),  mCycles);
      checkOutput("stalls",  32'(dutStalls),  mStalls);
      checkOutput("flushes", 32'(dutFlushes), mFlushes);
    end
    if (rule == 1) begin
      mState = 0; mCycles = 0; mStalls = 0; mFlushes = 0;
      mValid = 1'b1;
    end else begin
      if (rule != 2) mCycles  = (mCycles + 1) & CNT_MASK;
      if (rule == 3) mFlushes = (mFlushes + 1) & CNT_MASK;
      if (rule == 4) mStalls  = (mStalls + 1) & CNT_MASK;
      case (mState)
        0:       mState = halt ? 1 : 0;
        1:       mState = go ? 2 : 1;
        default: mState = 0;
      endcase
    end
  end

  // Directed scenarios with literal expectations, then a randomised soak
  initial begin
    rstN = 1'b0; idRs = 5'd3; idRt = 5'd3; rsUsed = 1'b1; rtUsed = 1'b1;
    exMemRead = 1'b1; exRw = 5'd3; exBranch = 1'b1; halt = 1'b1; go = 1'b1;

    applyStimulus(1'b0, 5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
    settle();
    checkOutput("resetCtl", 32'(dutCtl), 32'(CTL_RESET));
    checkOutput("resetState", 32'(dutState), 0);
    checkOutput("resetCycles", 32'(dutCycles), 0);

    quiet();
    settle();
    checkOutput("firstRunCtl", 32'(dutCtl), 32'(CTL_NORMAL));

    applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("loadUseCtl", 32'(dutCtl), 32'(CTL_STALL));
    quiet();
    settle();
    checkOutput("loadUseStalls", 32'(dutStalls), 1);
    checkOutput("loadUseCycles", 32'(dutCycles), 2);

    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("reg0NoStall", 32'(dutCtl), 32'(CTL_NORMAL));
    applyStimulus(1'b1, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("unusedNoStall", 32'(dutCtl), 32'(CTL_NORMAL));
    applyStimulus(1'b1, 5'd8, 5'd12, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("rtStallCtl", 32'(dutCtl), 32'(CTL_STALL));

    applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("branchCtl", 32'(dutCtl), 32'(CTL_FLUSH));
    quiet();
    settle();
    checkOutput("branchFlushes", 32'(dutFlushes), 1);
    checkOutput("branchStalls", 32'(dutStalls), 2);
    checkOutput("branchCycles", 32'(dutCycles), 7);

    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    settle();
    checkOutput("haltSameCycle", 32'(dutCtl), 32'(CTL_FREEZE));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      settle();
    end
    checkOutput("haltState", 32'(dutState), 1);
    checkOutput("haltCyclesFrozen", 32'(dutCycles), 8);

    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    settle();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    settle();
    checkOutput("resumeState", 32'(dutState), 2);
    checkOutput("resumeCtl", 32'(dutCtl), 32'(CTL_NORMAL));
    quiet();
    settle();
    checkOutput("afterResumeState", 32'(dutState), 0);
    checkOutput("afterResumeCycles", 32'(dutCycles), 9);

    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    settle();
    applyStimulus(1'b0, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1);
    settle();
    checkOutput("haltAndGoState", 32'(dutState), 1);
    checkOutput("resetInHaltCtl", 32'(dutCtl), 32'(CTL_RESET));
    quiet();
    settle();
    checkOutput("resetFromHaltState", 32'(dutState), 0);
    checkOutput("resetFromHaltCycles", 32'(dutCycles), 0);
    checkOutput("resetFromHaltStalls", 32'(dutStalls), 0);
    checkOutput("resetFromHaltFlushes", 32'(dutFlushes), 0);

    for (int i = 0; i < 17; i++) begin
      quiet();
    end
    settle();
    checkOutput("cyclesWrap", 32'(dutCycles), 1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)));
    end
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
